// File: rtl/rom_fetch_unit_if.sv
// CPU-side ROM fetch port.
// Request: req_valid/req_addr/req_ready handshake plus flush.
// Response: rsp_valid single-cycle pulse with rsp_data and pf_hit.
// The master is the CPU core. The slave is rom_fetch_unit.
interface rom_fetch_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORD_W = 16
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              flush;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_data;
  logic              pf_hit;

  modport master (
    output req_valid, req_addr, flush,
    input  req_ready, rsp_valid, rsp_data, pf_hit
  );

  modport slave (
    input  req_valid, req_addr, flush,
    output req_ready, rsp_valid, rsp_data, pf_hit
  );
endinterface

// File: rtl/rom_fetch_unit.sv
// ROM instruction fetcher for the 8-bit parallel flash.
// It builds WORD_W-bit instructions out of FLASH_W-bit flash beats. Each beat
// holds the flash address for WAIT_CYCLES+1 cycles. When PREFETCH=1, the word
// after the one just served is read ahead into a one-entry buffer.
// Ports:
//   CLOCK_50, reset_n   clock and synchronous active-low reset
//   bus (slave)         request/response handshake towards the CPU core
//   fl_addr             registered flash byte address
//   fl_dq               flash read data
//   fl_ce_n/oe_n/we_n   held permanently in read mode
//   fl_rst_n            follows reset_n
module rom_fetch_unit #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned FLASH_W      = 8,
  parameter int unsigned FLASH_ADDR_W = 22,
  parameter int unsigned WAIT_CYCLES  = 3,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned PREFETCH     = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  rom_fetch_unit_if.slave         bus,
  output logic [FLASH_ADDR_W-1:0] fl_addr,
  input  logic [FLASH_W-1:0]      fl_dq,
  output logic                    fl_ce_n,
  output logic                    fl_oe_n,
  output logic                    fl_we_n,
  output logic                    fl_rst_n
);

  localparam int unsigned BEATS  = WORD_W / FLASH_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RESP,
    ST_PREFETCH
  } state_t;

  state_t                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]       rsp_data_q, rsp_data_d;
  logic                    pf_hit_q, pf_hit_d;
  logic [FLASH_ADDR_W-1:0] fl_addr_q, fl_addr_d;
  logic [WORD_W-1:0]       buf_q, buf_d;        // demand assembly and prefetch buffer
  logic [ADDR_W-1:0]       pf_addr_q, pf_addr_d;
  logic                    pf_valid_q, pf_valid_d;
  logic [ADDR_W-1:0]       served_q, served_d;  // address of the word being answered
  logic                    hit_q, hit_d;        // current answer comes from the buffer
  logic                    pending_q, pending_d; // demand waiting on the running prefetch
  logic                    drop_q, drop_d;      // flush seen: no prefetch after RESP
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;

  logic sample, last_beat, accept, pf_match, start_miss;

  // First flash byte of ROM word a.
  function automatic logic [FLASH_ADDR_W-1:0] word_base(input logic [ADDR_W-1:0] a);
    return FLASH_ADDR_W'(BASE_ADDR) + FLASH_ADDR_W'(a) * FLASH_ADDR_W'(BEATS);
  endfunction

  assign sample    = (wait_q == WAIT_W'(WAIT_CYCLES));
  assign last_beat = sample && (beat_q == BEAT_W'(BEATS - 1));
  assign accept    = bus.req_valid && req_ready_q;
  assign pf_match  = (bus.req_addr == pf_addr_q);

  // State and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      pf_hit_q    <= 1'b0;
      fl_addr_q   <= '0;
      buf_q       <= '0;
      pf_addr_q   <= '0;
      pf_valid_q  <= 1'b0;
      served_q    <= '0;
      hit_q       <= 1'b0;
      pending_q   <= 1'b0;
      drop_q      <= 1'b0;
      wait_q      <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      pf_hit_q    <= pf_hit_d;
      fl_addr_q   <= fl_addr_d;
      buf_q       <= buf_d;
      pf_addr_q   <= pf_addr_d;
      pf_valid_q  <= pf_valid_d;
      served_q    <= served_d;
      hit_q       <= hit_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
      wait_q      <= wait_d;
      beat_q      <= beat_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    pf_hit_d    = 1'b0;
    fl_addr_d   = fl_addr_q;
    buf_d       = buf_q;
    pf_addr_d   = pf_addr_q;
    pf_valid_d  = pf_valid_q;
    served_d    = served_q;
    hit_d       = hit_q;
    pending_d   = pending_q;
    drop_d      = drop_q;
    wait_d      = wait_q;
    beat_d      = beat_q;
    start_miss  = 1'b0;

    // Beat engine: hold the address, then sample the byte and step to the next one.
    if (state_q == ST_FETCH || state_q == ST_PREFETCH) begin
      if (sample) begin
        buf_d[FLASH_W*32'(beat_q) +: FLASH_W] = fl_dq;
        fl_addr_d = fl_addr_q + FLASH_ADDR_W'(1);
        wait_d    = '0;
        beat_d    = last_beat ? '0 : beat_q + BEAT_W'(1);
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.flush) pf_valid_d = 1'b0;
        if (accept) begin
          if (pf_valid_q && !bus.flush && pf_match) begin
            served_d = bus.req_addr;
            hit_d    = 1'b1;
            state_d  = ST_RESP;
          end else begin
            start_miss = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        if (bus.flush) drop_d = 1'b1;
        if (last_beat) state_d = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid_d = 1'b1;
        pf_hit_d    = hit_q;
        rsp_data_d  = buf_q;
        pf_valid_d  = 1'b0;
        pending_d   = 1'b0;
        hit_d       = 1'b0;
        drop_d      = 1'b0;
        if (PREFETCH != 0 && !drop_q && !bus.flush) begin
          pf_addr_d = served_q + ADDR_W'(1);
          fl_addr_d = word_base(served_q + ADDR_W'(1));
          wait_d    = '0;
          beat_d    = '0;
          state_d   = ST_PREFETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PREFETCH: begin
        if (bus.flush) pf_valid_d = 1'b0;
        if (accept) begin
          if (!bus.flush && pf_match) begin
            pending_d = 1'b1;
            served_d  = bus.req_addr;
          end else begin
            start_miss = 1'b1;
          end
        end else if (bus.flush) begin
          if (pending_q) drop_d  = 1'b1;
          else           state_d = ST_IDLE;
        end
        // A demand matching on the final beat's edge is answered straight away.
        if (last_beat && !start_miss && state_d == ST_PREFETCH) begin
          if (pending_d) begin
            hit_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            pf_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A demand miss, either from IDLE or by aborting a prefetch, restarts at beat 0.
    if (start_miss) begin
      state_d    = ST_FETCH;
      fl_addr_d  = word_base(bus.req_addr);
      served_d   = bus.req_addr;
      wait_d     = '0;
      beat_d     = '0;
      hit_d      = 1'b0;
      pending_d  = 1'b0;
      drop_d     = 1'b0;
      pf_valid_d = 1'b0;
    end

    req_ready_d = (state_d == ST_IDLE) || (state_d == ST_PREFETCH && !pending_d);
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.pf_hit    = pf_hit_q;
  assign fl_addr       = fl_addr_q;
  assign fl_ce_n       = 1'b0;
  assign fl_oe_n       = 1'b0;
  assign fl_we_n       = 1'b1;
  assign fl_rst_n      = reset_n;

endmodule
